// File: rtl/rv32i_types_pkg.sv
// Shared RV32I memory-path types: load/store encodings, sequencer states,
// and small helpers for access size, alignment, lane enables and store replication.
package rv32i_types_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_t;

    typedef enum logic [1:0] {
        SW_BYTE = 2'b00,
        SW_HALF = 2'b01,
        SW_WORD = 2'b10
    } store_width_t;

    typedef enum logic [1:0] {
        MS_IDLE,
        MS_ACCESS,
        MS_DONE
    } mem_seq_state_t;

    // Access size is expressed with store_width_t for both directions; 2'b11 is treated as a word.
    function automatic store_width_t size_of_store(input logic [1:0] width);
        case (width)
            2'b00:   return SW_BYTE;
            2'b01:   return SW_HALF;
            default: return SW_WORD;
        endcase
    endfunction

    function automatic store_width_t size_of_load(input load_t lt);
        case (lt)
            LB, LBU: return SW_BYTE;
            LH, LHU: return SW_HALF;
            default: return SW_WORD;
        endcase
    endfunction

    function automatic logic is_aligned(input store_width_t size, input logic [1:0] lane);
        case (size)
            SW_BYTE: return 1'b1;
            SW_HALF: return ~lane[0];
            default: return (lane == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_en_of(input store_width_t size, input logic [1:0] lane);
        case (size)
            SW_BYTE: return 4'b0001 << lane;
            SW_HALF: return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_of(input store_width_t size, input logic [31:0] d);
        case (size)
            SW_BYTE: return {4{d[7:0]}};
            SW_HALF: return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_sequencer_load_extender.sv
// Selects the addressed byte/half of a bus read word and sign- or zero-extends it
// according to the load type; words pass straight through.
module load_extender
    import rv32i_types_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  load_t       load_type,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (lane)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

        case (load_type)
            LB:      result = {{24{byte_sel[7]}}, byte_sel};
            LBU:     result = {24'b0, byte_sel};
            LH:      result = {{16{half_sel[15]}}, half_sel};
            LHU:     result = {16'b0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// Runs one data-bus transaction per load/store, stalling the pipeline until the bus
// completes or times out, and returns the extended load result with a done pulse.
module mem_access_sequencer
    import rv32i_types_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 1024
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dren,
    input  logic        dwen,
    input  load_t       load_type,
    input  logic [1:0]  store_width,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] bus_rdata,
    input  logic        bus_busy,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_ren,
    output logic        bus_wen,
    output logic [3:0]  bus_byte_en,
    output logic        stall_mem,
    output logic [31:0] load_data,
    output logic        done,
    output logic        mal_l,
    output logic        mal_s,
    output logic        bus_err
);

    localparam int CNT_W = (BUS_TIMEOUT > 2) ? $clog2(BUS_TIMEOUT) : 1;
    localparam bit TO_EN = (BUS_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((BUS_TIMEOUT == 0) ? 0 : BUS_TIMEOUT - 1);

    mem_seq_state_t    state_q, state_d;
    logic [31:0]       bus_addr_q, bus_addr_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic              bus_ren_q, bus_ren_d;
    logic              bus_wen_q, bus_wen_d;
    logic [3:0]        byte_en_q, byte_en_d;
    logic [31:0]       load_data_q, load_data_d;
    logic              done_q, done_d;
    logic              bus_err_q, bus_err_d;
    logic [1:0]        lane_q, lane_d;
    load_t             ld_type_q, ld_type_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic         req;
    logic         req_ok;
    store_width_t req_size;
    logic [31:0]  ext_result;

    load_extender u_load_extender (
        .rdata     (bus_rdata),
        .lane      (lane_q),
        .load_type (ld_type_q),
        .result    (ext_result)
    );

    // Store wins when both requests are raised, so the size comes from the store path.
    assign req      = dren | dwen;
    assign req_size = dwen ? size_of_store(store_width) : size_of_load(load_type);
    assign req_ok   = is_aligned(req_size, addr[1:0]);

    assign mal_l     = (state_q == MS_IDLE) & dren & ~dwen & ~req_ok;
    assign mal_s     = (state_q == MS_IDLE) & dwen & ~req_ok;
    assign stall_mem = ((state_q == MS_IDLE) & req & req_ok) | (state_q == MS_ACCESS);

    always_comb begin
        // NOTE: every _d starts from its _q so no path through the case leaves a signal unassigned (no latches).
        state_d     = state_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_ren_d   = bus_ren_q;
        bus_wen_d   = bus_wen_q;
        byte_en_d   = byte_en_q;
        load_data_d = load_data_q;
        lane_d      = lane_q;
        ld_type_d   = ld_type_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        bus_err_d   = 1'b0;

        case (state_q)
            MS_IDLE: begin
                if (req && req_ok) begin
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_wdata_d = dwen ? wdata_of(req_size, store_data) : 32'b0;
                    byte_en_d   = byte_en_of(req_size, addr[1:0]);
                    bus_wen_d   = dwen;
                    bus_ren_d   = ~dwen;
                    lane_d      = addr[1:0];
                    ld_type_d   = load_type;
                    cnt_d       = '0;
                    state_d     = MS_ACCESS;
                end
            end
            MS_ACCESS: begin
                if (!bus_busy) begin
                    if (bus_ren_q) load_data_d = ext_result;
                    bus_ren_d = 1'b0;
                    bus_wen_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = MS_DONE;
                end else if (TO_EN && cnt_q == TO_LAST) begin
                    load_data_d = 32'b0;
                    bus_ren_d   = 1'b0;
                    bus_wen_d   = 1'b0;
                    bus_err_d   = 1'b1;
                    done_d      = 1'b1;
                    state_d     = MS_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // The pipeline advances at the end of DONE, so IDLE never re-sees this instruction.
            default: state_d = MS_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= MS_IDLE;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_ren_q   <= 1'b0;
            bus_wen_q   <= 1'b0;
            byte_en_q   <= '0;
            load_data_q <= '0;
            done_q      <= 1'b0;
            bus_err_q   <= 1'b0;
            lane_q      <= '0;
            ld_type_q   <= LB;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_ren_q   <= bus_ren_d;
            bus_wen_q   <= bus_wen_d;
            byte_en_q   <= byte_en_d;
            load_data_q <= load_data_d;
            done_q      <= done_d;
            bus_err_q   <= bus_err_d;
            lane_q      <= lane_d;
            ld_type_q   <= ld_type_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign bus_ren     = bus_ren_q;
    assign bus_wen     = bus_wen_q;
    assign bus_byte_en = byte_en_q;
    assign load_data   = load_data_q;
    assign done        = done_q;
    assign bus_err     = bus_err_q;

endmodule
